// File: rtl/pong_pkg.sv
// Shared types and constants for the ping-pong score path.
// Scores are two-digit BCD {tens,units}; sides are encoded 0 = left, 1 = right.
// Pure declarations, no logic.
package pong_pkg;

  typedef logic [7:0] bcd2_t;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } score_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  localparam bcd2_t BCD_MAX = 8'h99;

  // Lead register saturates symmetrically so it can never wrap sign.
  localparam logic signed [7:0] LEAD_MAX = 8'sd127;
  localparam logic signed [7:0] LEAD_MIN = -8'sd127;

endpackage

// File: rtl/bcd_add1_2d.sv
// Two-digit BCD increment, saturating at 99; passes the input through when disabled.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module bcd_add1_2d
  import pong_pkg::*;
(
  input  logic  i_en,
  input  bcd2_t i_val,
  output bcd2_t o_val
);

  logic [3:0] w_tens;
  logic [3:0] w_units;

  assign w_tens  = i_val[7:4];
  assign w_units = i_val[3:0];

  // Units 9 rolls to 0 and carries into tens; 99 holds.
  always_comb begin
    o_val = i_val;
    if (i_en && (i_val != BCD_MAX)) begin
      if (w_units == 4'd9) begin
        o_val = {w_tens + 4'd1, 4'd0};
      end else begin
        o_val = {w_tens, w_units + 4'd1};
      end
    end
  end

endmodule

// File: rtl/pong_score_ctrl.sv
// Score keeper: BCD scores, lead, win detection and serve rotation for one game.
// Latency: 1 cycle from a sampled pulse to registered outputs.
// Backpressure: none; every cycle's pulses are consumed, new_game beats points.
module pong_score_ctrl
  import pong_pkg::*;
#(
  parameter bcd2_t WIN_SCORE  = 8'h11,
  parameter bit    WIN_BY_TWO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pt_left,
  input  logic       pt_right,
  input  logic       new_game,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic       serve_side
);

  // Both scores at or above this put the game in the alternating-serve region.
  localparam bcd2_t DEUCE_SCORE = WIN_SCORE - 8'd1;

  score_state_t      r_state,     w_state_nxt;
  bcd2_t             r_score_l,   w_score_l_nxt;
  bcd2_t             r_score_r,   w_score_r_nxt;
  logic signed [7:0] r_lead,      w_lead_nxt;
  logic              r_parity,    w_parity_nxt;
  logic              r_game_over, w_game_over_nxt;
  side_t             r_winner,    w_winner_nxt;
  side_t             r_serve,     w_serve_nxt;

  logic              w_accept;
  logic              w_acc_l;
  logic              w_acc_r;
  bcd2_t             w_inc_l;
  bcd2_t             w_inc_r;
  logic signed [7:0] w_lead_upd;
  logic              w_deuce;
  logic              w_elig_l;
  logic              w_elig_r;

  // A point counts only while playing and only when exactly one side pulses.
  assign w_accept = (r_state == PLAY) && (pt_left ^ pt_right);
  assign w_acc_l  = w_accept && pt_left;
  assign w_acc_r  = w_accept && pt_right;

  bcd_add1_2d u_add_left (
    .i_en  (w_acc_l),
    .i_val (r_score_l),
    .o_val (w_inc_l)
  );

  bcd_add1_2d u_add_right (
    .i_en  (w_acc_r),
    .i_val (r_score_r),
    .o_val (w_inc_r)
  );

  // Lead moves toward the scorer and saturates at +/-127.
  always_comb begin
    w_lead_upd = r_lead;
    if (w_acc_l && (r_lead != LEAD_MAX)) begin
      w_lead_upd = r_lead + 8'sd1;
    end else if (w_acc_r && (r_lead != LEAD_MIN)) begin
      w_lead_upd = r_lead - 8'sd1;
    end
  end

  // Post-update scores are used so the winning point and deuce serve are judged together.
  assign w_deuce  = (w_inc_l >= DEUCE_SCORE) && (w_inc_r >= DEUCE_SCORE);
  assign w_elig_l = w_acc_l && (w_inc_l >= WIN_SCORE) &&
                    (!WIN_BY_TWO || (w_lead_upd >= 8'sd2));
  assign w_elig_r = w_acc_r && (w_inc_r >= WIN_SCORE) &&
                    (!WIN_BY_TWO || (w_lead_upd <= -8'sd2));

  // Next-state and next-output selection: new_game first, then accepted points.
  always_comb begin
    w_state_nxt     = r_state;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_lead_nxt      = r_lead;
    w_parity_nxt    = r_parity;
    w_game_over_nxt = r_game_over;
    w_winner_nxt    = r_winner;
    w_serve_nxt     = r_serve;
    if (new_game) begin
      w_state_nxt     = PLAY;
      w_score_l_nxt   = 8'h00;
      w_score_r_nxt   = 8'h00;
      w_lead_nxt      = 8'sd0;
      w_parity_nxt    = 1'b0;
      w_game_over_nxt = 1'b0;
      w_winner_nxt    = LEFT;
      // The loser of a finished game serves first; otherwise left serves.
      w_serve_nxt     = (r_state == OVER) ? side_t'(~r_winner) : LEFT;
    end else if (w_accept) begin
      w_score_l_nxt = w_inc_l;
      w_score_r_nxt = w_inc_r;
      w_lead_nxt    = w_lead_upd;
      w_parity_nxt  = ~r_parity;
      // Parity wrapping 1->0 marks every second point; deuce flips every point.
      if (w_deuce || r_parity) begin
        w_serve_nxt = side_t'(~r_serve);
      end
      if (w_elig_l || w_elig_r) begin
        w_state_nxt     = OVER;
        w_game_over_nxt = 1'b1;
        w_winner_nxt    = w_elig_r ? RIGHT : LEFT;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= PLAY;
      r_score_l   <= 8'h00;
      r_score_r   <= 8'h00;
      r_lead      <= 8'sd0;
      r_parity    <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= LEFT;
      r_serve     <= LEFT;
    end else begin
      r_state     <= w_state_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_lead      <= w_lead_nxt;
      r_parity    <= w_parity_nxt;
      r_game_over <= w_game_over_nxt;
      r_winner    <= w_winner_nxt;
      r_serve     <= w_serve_nxt;
    end
  end

  assign score_left  = r_score_l;
  assign score_right = r_score_r;
  assign game_over   = r_game_over;
  assign winner      = r_winner;
  assign serve_side  = r_serve;

endmodule
